// File: rtl/mux_key_table_if.sv
// mux_key_table_if: bundles the table write port, the lookup request channel
// and the lookup response channel of mux_key_table.
// Ports (by modport):
//   slave  (table side): inputs  wr_en/wr_del/wr_key/wr_data, req_valid/req_key,
//                        default_out, rsp_ready;
//                        outputs wr_drop, count, full, req_ready,
//                        rsp_valid/rsp_data/rsp_hit
//   master (user side):  the mirror image of slave.
interface mux_key_table_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 32
);
  localparam int CNT_W = $clog2(NR_KEY + 1);

  // Table write/delete command
  logic                wr_en;
  logic                wr_del;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_drop;
  logic [CNT_W-1:0]    count;
  logic                full;

  // Lookup request
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic [DATA_LEN-1:0] default_out;

  // Lookup response
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_LEN-1:0] rsp_data;
  logic                rsp_hit;

  modport slave (
    input  wr_en, wr_del, wr_key, wr_data,
    output wr_drop, count, full,
    input  req_valid, req_key, default_out,
    output req_ready,
    output rsp_valid, rsp_data, rsp_hit,
    input  rsp_ready
  );

  modport master (
    output wr_en, wr_del, wr_key, wr_data,
    input  wr_drop, count, full,
    output req_valid, req_key, default_out,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_hit,
    output rsp_ready
  );
endinterface

// File: rtl/mux_key_table.sv
// mux_key_table: small fully-associative key->data table with one write/delete
// port and one lookup port; lookup result registered, 1-cycle latency.
// Backpressure: req_ready = !rsp_valid || rsp_ready; a stalled response is held
// unchanged (including across table writes) until rsp_ready.
// Ports:
//   clk  - clock;  rst - synchronous active-high reset
//   bus  - mux_key_table_if.slave (write command, lookup request, lookup response)
module mux_key_table #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mux_key_table_if.slave     bus
);

  localparam int CNT_W = $clog2(NR_KEY + 1);
  localparam int IDX_W = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NR_KEY);

  // Table storage. Only the valid bits are reset; key/data of an invalid
  // entry are don't-care because every match is qualified by the valid bit.
  logic [NR_KEY-1:0]   r_vld;
  logic [KEY_LEN-1:0]  r_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];

  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_wr_drop;

  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic [DATA_LEN-1:0] r_rsp_data;

  logic [NR_KEY-1:0]   w_wr_match;
  logic [NR_KEY-1:0]   w_req_match;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_has_free;
  logic [DATA_LEN-1:0] w_hit_data;
  logic [DATA_LEN-1:0] w_miss_data;
  logic [CNT_W-1:0]    w_count_nxt;

  logic w_ins;
  logic w_del;
  logic w_wr_hit;
  logic w_ins_new;
  logic w_ins_drop;
  logic w_del_hit;
  logic w_req_ready;
  logic w_acc;

  // Key comparators for the write port and the lookup port. Both look at the
  // table as it stands this cycle, so a same-cycle insert is not visible to
  // the lookup.
  always_comb begin
    w_wr_match  = '0;
    w_req_match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      w_wr_match[i]  = r_vld[i] && (r_key[i] == bus.wr_key);
      w_req_match[i] = r_vld[i] && (r_key[i] == bus.req_key);
    end
  end

  // Lowest-index free entry: scan downwards so the last assignment wins.
  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_free_idx = IDX_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  // Keys are unique among valid entries, so at most one match bit is set and
  // an AND-OR mux is enough.
  always_comb begin
    w_hit_data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_req_match[i]) begin
        w_hit_data = w_hit_data | r_data[i];
      end
    end
  end

  assign w_miss_data = (HAS_DEFAULT != 0) ? bus.default_out : '0;

  // Write command decode
  assign w_ins      = bus.wr_en && !bus.wr_del;
  assign w_del      = bus.wr_en &&  bus.wr_del;
  assign w_wr_hit   = |w_wr_match;
  assign w_ins_new  = w_ins && !w_wr_hit &&  w_has_free;
  assign w_ins_drop = w_ins && !w_wr_hit && !w_has_free;
  assign w_del_hit  = w_del &&  w_wr_hit;

  always_comb begin
    w_count_nxt = r_count;
    if (w_ins_new) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_del_hit) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Key/data storage: update in place on a key hit, otherwise claim the
  // lowest free entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_ins && w_wr_match[i]) begin
        r_data[i] <= bus.wr_data;
      end else if (w_ins_new && (w_free_idx == IDX_W'(i))) begin
        r_key[i]  <= bus.wr_key;
        r_data[i] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (w_ins_new && (w_free_idx == IDX_W'(i))) begin
          r_vld[i] <= 1'b1;
        end else if (w_del_hit && w_wr_match[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == FULL_CNT);
      r_wr_drop <= w_ins_drop;
    end
  end

  // Lookup response register: loads only on acceptance, so a stalled result
  // is immune to later table writes.
  assign w_req_ready = !r_rsp_valid || bus.rsp_ready;
  assign w_acc       = bus.req_valid && w_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= |w_req_match;
      r_rsp_data  <= (|w_req_match) ? w_hit_data : w_miss_data;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.wr_drop   = r_wr_drop;
  assign bus.count     = r_count;
  assign bus.full      = r_full;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_hit   = r_rsp_hit;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: doc/mux_key_table.md
MUX_KEY_TABLE -- requirements
Module: mux_key_table

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (>=1).
REQ-002 SHALL have parameter KEY_LEN, default 4, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 32, data width in bits.
REQ-004 SHALL have parameter HAS_DEFAULT, default 1; 1 = miss returns default_out, 0 = miss returns zero.
REQ-005 SHALL use one clock `clk`; reset `rst` is synchronous and active-high.
REQ-006 SHALL have ports:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  wr_en  in  1  table write/delete command valid
  wr_del  in  1  1 = delete wr_key, 0 = insert/update
  wr_key  in  KEY_LEN  key to write/delete
  wr_data  in  DATA_LEN  data for insert/update
  wr_drop  out  1  one-cycle pulse: insert rejected, table full
  count  out  $clog2(NR_KEY+1)  number of valid entries
  full  out  1  count == NR_KEY
  req_valid  in  1  lookup request valid
  req_ready  out  1  lookup request accepted when high with req_valid
  req_key  in  KEY_LEN  lookup key
  default_out  in  DATA_LEN  miss value (used when HAS_DEFAULT=1)
  rsp_valid  out  1  lookup result valid
  rsp_ready  in  1  consumer accepts result
  rsp_data  out  DATA_LEN  lookup result data
  rsp_hit  out  1  1 = key matched a valid entry

Function
REQ-007 SHALL hold NR_KEY entries, each {valid, key, data}; no two valid entries SHALL ever hold the same key.
REQ-008 Insert (wr_en=1, wr_del=0): key matches valid entry -> that entry's data replaced, count unchanged.
REQ-009 Insert, no match, free entry exists -> lowest-index invalid entry takes key/data, set valid, count+1.
REQ-010 Insert, no match, table full -> table unchanged, wr_drop=1 for exactly the next cycle.
REQ-011 Delete (wr_en=1, wr_del=1): matching valid entry invalidated, count-1; no match -> no-op, no wr_drop.
REQ-012 Table updates SHALL take effect at the clock edge ending the command cycle; one command per cycle.
REQ-013 req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally.
REQ-014 Lookup accepted (req_valid && req_ready) -> at next edge rsp_valid=1, rsp_hit/rsp_data registered; latency exactly 1 cycle.
REQ-015 Lookup SHALL compare against table contents before any same-cycle write (write-after-read; same-cycle insert not visible).
REQ-016 Hit -> rsp_data = matched entry data, rsp_hit=1.
REQ-017 Miss -> rsp_hit=0, rsp_data = default_out sampled at acceptance if HAS_DEFAULT=1, else all zeros.
REQ-018 rsp_valid && !rsp_ready -> rsp_valid, rsp_data, rsp_hit held stable; later table writes SHALL NOT alter held result.
REQ-019 rsp_valid && rsp_ready && no new acceptance -> rsp_valid=0 next cycle; with new acceptance -> back-to-back result, full throughput.
REQ-020 count/full SHALL be registered, reflecting table after last edge; count never exceeds NR_KEY or underflows.
REQ-021 wr_en=0 -> table, count unchanged, wr_drop=0.

Reset
REQ-022 rst=1 at an edge SHALL clear all valid bits, count=0, full=0, wr_drop=0, rsp_valid=0, rsp_hit=0, rsp_data=0.
REQ-023 rst SHALL override simultaneous writes and lookups; a pending unaccepted response is discarded.
REQ-024 Key/data storage of invalid entries need not be reset; they SHALL never produce a hit.

Verification
REQ-025 Insert keys 1,2,3 data 0xA,0xB,0xC; lookup key 2 -> next cycle rsp_valid=1, rsp_hit=1, rsp_data=0xB; count=3.
REQ-026 HAS_DEFAULT=1, default_out=0xDEAD, lookup absent key 7 -> rsp_hit=0, rsp_data=0xDEAD; HAS_DEFAULT=0 -> rsp_data=0.
REQ-027 NR_KEY=4: fill with keys 1-4, insert key 5 -> wr_drop pulses 1 cycle, full=1; re-insert key 3 data 0x33 -> no drop, lookup 3 returns 0x33.
REQ-028 Delete key 2 then insert key 9 -> key 9 occupies entry 1 (lowest free), count unchanged after both; lookup 2 misses.
REQ-029 rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_data stable; insert to same key meanwhile does not change held rsp_data; rsp_ready=1 -> next request accepted same cycle.
REQ-030 Same-cycle insert key 6 and lookup key 6 -> miss; lookup next cycle -> hit; assert rst mid-stream -> all outputs zero next cycle, previous keys miss.
